// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Define ADDER_FLAGS_EN to build the registered Z/N/V flag outputs.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v
);
    localparam int NGRP = WIDTH / 4;

    if (GROUP != 4 || (WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_cfg_err
        $error("pipelined_cla_adder: GROUP must be 4 and WIDTH a multiple of 4 in 4..64");
    end

    logic [WIDTH-1:0] w_b_eff, w_p, w_g;
    logic [NGRP-1:0]  w_gp, w_gg;
    logic             w_cin_eff, w_accept, w_s2_adv;

    logic             r_s1_valid, r_cin, r_a_msb, r_b_msb;
    logic [WIDTH-1:0] r_p, r_g;
    logic [NGRP-1:0]  r_gp, r_gg;

    logic [NGRP:0]    w_gc;
    logic [WIDTH-1:0] w_c, w_sum;
    logic             w_la_c, w_la_p;

    logic             r_out_valid, r_cout;
    logic [WIDTH-1:0] r_sum;

    assign w_s2_adv = r_s1_valid & (~r_out_valid | out_ready);
    assign in_ready = ~r_s1_valid | w_s2_adv;
    assign w_accept = in_valid & in_ready;

    assign w_b_eff   = in_sub ? ~in_b : in_b;
    assign w_cin_eff = in_sub | in_cin;
    assign w_p       = in_a ^ w_b_eff;
    assign w_g       = in_a & w_b_eff;

    always_comb begin
        w_gp = '0;
        w_gg = '0;
        for (int k = 0; k < NGRP; k++) begin
            w_gp[k] = &w_p[4*k +: 4];
            w_gg[k] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_p        <= '0;
            r_g        <= '0;
            r_gp       <= '0;
            r_gg       <= '0;
            r_cin      <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_p        <= w_p;
                r_g        <= w_g;
                r_gp       <= w_gp;
                r_gg       <= w_gg;
                r_cin      <= w_cin_eff;
                r_a_msb    <= in_a[WIDTH-1];
                r_b_msb    <= w_b_eff[WIDTH-1];
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Second-level lookahead: each group carry is a flat sum of products, not a ripple chain.
    always_comb begin
        w_gc    = '0;
        w_gc[0] = r_cin;
        w_la_c  = 1'b0;
        w_la_p  = 1'b1;
        for (int k = 0; k < NGRP; k++) begin
            w_la_c = 1'b0;
            w_la_p = 1'b1;
            for (int j = k; j >= 0; j--) begin
                w_la_c = w_la_c | (w_la_p & r_gg[j]);
                w_la_p = w_la_p & r_gp[j];
            end
            w_gc[k+1] = w_la_c | (w_la_p & r_cin);
        end
    end

    always_comb begin
        w_c = '0;
        for (int k = 0; k < NGRP; k++) begin
            w_c[4*k]   = w_gc[k];
            w_c[4*k+1] = r_g[4*k] | (r_p[4*k] & w_gc[k]);
            w_c[4*k+2] = r_g[4*k+1] | (r_p[4*k+1] & r_g[4*k])
                       | (r_p[4*k+1] & r_p[4*k] & w_gc[k]);
            w_c[4*k+3] = r_g[4*k+2] | (r_p[4*k+2] & r_g[4*k+1])
                       | (r_p[4*k+2] & r_p[4*k+1] & r_g[4*k])
                       | (r_p[4*k+2] & r_p[4*k+1] & r_p[4*k] & w_gc[k]);
        end
    end

    assign w_sum = r_p ^ w_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_out_valid <= 1'b1;
                r_sum       <= w_sum;
                r_cout      <= w_gc[NGRP];
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;

`ifdef ADDER_FLAGS_EN
    logic r_z, r_n, r_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z <= 1'b0;
            r_n <= 1'b0;
            r_v <= 1'b0;
        end else if (w_s2_adv) begin
            r_z <= ~|w_sum;
            r_n <= w_sum[WIDTH-1];
            r_v <= (r_a_msb == r_b_msb) & (w_sum[WIDTH-1] != r_a_msb);
        end
    end

    assign out_z = r_z;
    assign out_n = r_n;
    assign out_v = r_v;
`else
    logic w_unused_msb;
    assign w_unused_msb = r_a_msb ^ r_b_msb;
    assign out_z = 1'b0;
    assign out_n = 1'b0;
    assign out_v = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed corner cases, stall/reset scenarios
// and randomized traffic checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pipelined_cla_adder;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned MAX_WAIT = 50;
    localparam int unsigned N_RAND   = 3000;

    localparam logic [WIDTH-1:0] ALL1 = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] NEG2 = {{(WIDTH-1){1'b1}}, 1'b0};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0, in_ready;
    logic [WIDTH-1:0] in_a = '0, in_b = '0;
    logic             in_cin = 1'b0, in_sub = 1'b0;
    logic             out_valid, out_ready = 1'b1;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout, out_z, out_n, out_v;

    pipelined_cla_adder #(.WIDTH(WIDTH), .GROUP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_z     (out_z),
        .out_n     (out_n),
        .out_v     (out_v)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             z;
        logic             n;
        logic             v;
    } res_t;

    res_t             exp_q[$];
    int unsigned      n_total = 0;
    int unsigned      n_bad   = 0;
    logic             hold_prev = 1'b0;
    logic [WIDTH-1:0] hold_sum  = '0;
    bit               rand_done = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain modular arithmetic; overflow from a one-bit sign-extended sum.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   uns, sgn;
        logic             ce;
        res_t             r;
        bb    = sub ? ~b : b;
        ce    = sub | cin;
        uns   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ce};
        sgn   = {a[WIDTH-1], a} + {bb[WIDTH-1], bb} + {{WIDTH{1'b0}}, ce};
        r.sum  = uns[WIDTH-1:0];
        r.cout = uns[WIDTH];
        r.z    = (uns[WIDTH-1:0] == '0);
        r.n    = uns[WIDTH-1];
        r.v    = sgn[WIDTH] != sgn[WIDTH-1];
`ifndef ADDER_FLAGS_EN
        r.z = 1'b0;
        r.n = 1'b0;
        r.v = 1'b0;
`endif
        return r;
    endfunction

    // Scoreboard: inputs and outputs are stable mid-cycle, so handshakes are sampled on negedge.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check_eq("hold_valid", out_valid, 1'b1);
                check_eq("hold_sum", out_sum, hold_sum);
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_sum", out_sum, e.sum);
                    check_eq("sb_cout", out_cout, e.cout);
                    check_eq("sb_z", out_z, e.z);
                    check_eq("sb_n", out_n, e.n);
                    check_eq("sb_v", out_v, e.v);
                end
            end
            hold_prev = out_valid && !out_ready;
            hold_sum  = out_sum;
        end
    end

    task automatic send_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic cin, input logic sub);
        bit done;
        done     = 1'b0;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        for (int i = 0; i < MAX_WAIT && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check_eq("accept_timeout", in_ready, 1'b1);
    endtask

    task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub, input logic [WIDTH-1:0] es,
                            input logic ec, input logic ez, input logic en, input logic ev);
        out_ready = 1'b1;
        send_beat(a, b, cin, sub);
        in_valid = 1'b0;
        check_eq({tag, "_lat1"}, out_valid, 1'b0);
        @(posedge clk);
        #1;
        check_eq({tag, "_lat2"}, out_valid, 1'b1);
        check_eq({tag, "_sum"}, out_sum, es);
        check_eq({tag, "_cout"}, out_cout, ec);
`ifdef ADDER_FLAGS_EN
        check_eq({tag, "_z"}, out_z, ez);
        check_eq({tag, "_n"}, out_n, en);
        check_eq({tag, "_v"}, out_v, ev);
`else
        if (ez | en | ev | 1'b1) begin
            check_eq({tag, "_flags_off"}, {out_z, out_n, out_v}, 3'b000);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < MAX_WAIT && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check_eq(tag, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return ALL1;
            2:       return MAXP;
            3:       return MINN;
            default: return r[WIDTH-1:0];
        endcase
    endfunction

    initial begin
        logic [WIDTH-1:0] held;
        bit               seen;

        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_sum", out_sum, '0);
        check_eq("rst_out_cout", out_cout, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        directed("t1_wrap", ALL1, ONE, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        directed("t2_sub", WIDTH'(5), WIDTH'(7), 1'b0, 1'b1, NEG2, 1'b0, 1'b0, 1'b1, 1'b0);
        directed("t2_sub_cin", WIDTH'(5), WIDTH'(7), 1'b1, 1'b1, NEG2, 1'b0, 1'b0, 1'b1, 1'b0);
        directed("t3_posovf", MAXP, ONE, 1'b0, 1'b0, MINN, 1'b0, 1'b0, 1'b1, 1'b1);
        directed("t3_negovf", MINN, ONE, 1'b0, 1'b1, MAXP, 1'b1, 1'b0, 1'b0, 1'b1);
        directed("t_cin", WIDTH'(3), WIDTH'(4), 1'b1, 1'b0, WIDTH'(8), 1'b0, 1'b0, 1'b0, 1'b0);
        drain("drain_directed");

        // Back-to-back stream with a three-cycle consumer stall after the first result.
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) send_beat(rnd_word(), rnd_word(), 1'($urandom), 1'(i));
                in_valid = 1'b0;
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < MAX_WAIT && !seen; i++) begin
                    @(negedge clk);
                    seen = out_valid && out_ready;
                end
                if (!seen) check_eq("stall_first_out", out_valid, 1'b1);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    if (i == 0) held = out_sum;
                    check_eq("stall_in_ready", in_ready, 1'b0);
                    check_eq("stall_out_valid", out_valid, 1'b1);
                    if (i > 0) check_eq("stall_sum", out_sum, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send_beat(rnd_word(), rnd_word(), 1'b0, 1'b0);
        send_beat(rnd_word(), rnd_word(), 1'b1, 1'b0);
        in_valid = 1'b0;
        check_eq("pre_rst_in_ready", in_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", out_valid, 1'b0);
        check_eq("async_rst_sum", out_sum, '0);
        check_eq("async_rst_ready", in_ready, 1'b1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        check_eq("post_rst_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("no_stale_beat", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random consumer back-pressure.
        fork
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < N_RAND; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send_beat(rnd_word(), rnd_word(), 1'($urandom), 1'($urandom));
                end
                in_valid  = 1'b0;
                rand_done = 1'b1;
            end
        join
        drain("drain_random");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
